// File: rtl/gp_register_bank.sv
// gp_register_bank
//   General-purpose register bank with a combinational bus read port, one
//   external write port, and a small sequencer that moves or swaps registers
//   internally without using the shared bus.
//
// Ports
//   clock    : system clock, rising edge
//   clear    : synchronous active-low reset
//   bus_in   : value written by an external write
//   wr_en    : external write strobe (dropped while the sequencer is busy)
//   wr_sel   : external write target
//   rd_sel   : register driven on rd_data
//   ba_out   : base-address mode; gates R0 to zero when R0_GATED=1
//   rd_data  : combinational read of R[rd_sel]
//   op_req   : request a move/swap (accepted in IDLE or DONE)
//   op_swap  : 0 = move R[a] -> R[b], 1 = swap R[a] and R[b]
//   op_a     : first operand register
//   op_b     : second operand register
//   op_busy  : sequencer in T1..T3
//   op_done  : one-cycle completion pulse
//   wr_drop  : external write discarded because the sequencer is busy
//   written  : sticky per-register "written since reset" mask
module gp_register_bank #(
    parameter int unsigned      WIDTH       = 32,
    parameter int unsigned      NUM_REGS    = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter bit               R0_GATED    = 1'b1,
    localparam int unsigned     SEL_W       = $clog2(NUM_REGS)
) (
    input  logic                clock,
    input  logic                clear,
    input  logic [WIDTH-1:0]    bus_in,
    input  logic                wr_en,
    input  logic [SEL_W-1:0]    wr_sel,
    input  logic [SEL_W-1:0]    rd_sel,
    input  logic                ba_out,
    output logic [WIDTH-1:0]    rd_data,
    input  logic                op_req,
    input  logic                op_swap,
    input  logic [SEL_W-1:0]    op_a,
    input  logic [SEL_W-1:0]    op_b,
    output logic                op_busy,
    output logic                op_done,
    output logic                wr_drop,
    output logic [NUM_REGS-1:0] written
);

    typedef enum logic [2:0] {
        IDLE,
        T1,
        T2,
        T3,
        DONE
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [WIDTH-1:0]   regs [NUM_REGS];
    logic [WIDTH-1:0]   temp;
    logic [SEL_W-1:0]   lat_a;
    logic [SEL_W-1:0]   lat_b;
    logic               lat_swap;
    logic               accept;
    logic               ext_wr;

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        op_busy    = 1'b0;
        op_done    = 1'b0;
        unique case (state)
            IDLE: begin
                accept = op_req;
                if (op_req) next_state = T1;
            end
            T1: begin
                op_busy    = 1'b1;
                next_state = T2;
            end
            T2: begin
                op_busy    = 1'b1;
                next_state = lat_swap ? T3 : DONE;
            end
            T3: begin
                op_busy    = 1'b1;
                next_state = DONE;
            end
            DONE: begin
                op_done    = 1'b1;
                accept     = op_req;
                next_state = op_req ? T1 : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign ext_wr  = wr_en & ~op_busy;
    assign wr_drop = wr_en & op_busy;

    // R0 gating only affects the bus view; the stored value is untouched.
    always_comb begin
        if (R0_GATED && ba_out && (rd_sel == '0)) begin
            rd_data = '0;
        end else begin
            rd_data = regs[rd_sel];
        end
    end

    // External writes land only in IDLE/DONE, sequencer writes only in T2/T3,
    // so the two never target the bank on the same edge. A write on the
    // acceptance edge is therefore seen by the T1 capture of R[a].
    always_ff @(posedge clock) begin
        if (!clear) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VALUE;
            end
            temp     <= '0;
            written  <= '0;
            lat_a    <= '0;
            lat_b    <= '0;
            lat_swap <= 1'b0;
            state    <= IDLE;
        end else begin
            state <= next_state;
            if (accept) begin
                lat_a    <= op_a;
                lat_b    <= op_b;
                lat_swap <= op_swap;
            end
            if (ext_wr) begin
                regs[wr_sel]    <= bus_in;
                written[wr_sel] <= 1'b1;
            end
            unique case (state)
                T1: temp <= regs[lat_a];
                T2: begin
                    if (lat_swap) begin
                        regs[lat_a]    <= regs[lat_b];
                        written[lat_a] <= 1'b1;
                    end else begin
                        regs[lat_b]    <= temp;
                        written[lat_b] <= 1'b1;
                    end
                end
                T3: begin
                    regs[lat_b]    <= temp;
                    written[lat_b] <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gp_register_bank.sv
// tb_gp_register_bank
//   Scoreboard bench for gp_register_bank. Stimulus updates an abstract
//   register-file model and queues expectations; a negedge monitor pops
//   and compares. A second, small instance (4 x 8 bits) covers the
//   parametrised build with a mid-operation reset and a move.
module tb_gp_register_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 16 x 32 instance
    logic        clear;
    logic [31:0] bus_in;
    logic        wr_en;
    logic [3:0]  wr_sel;
    logic [3:0]  rd_sel;
    logic        ba_out;
    logic [31:0] rd_data;
    logic        op_req;
    logic        op_swap;
    logic [3:0]  op_a;
    logic [3:0]  op_b;
    logic        op_busy;
    logic        op_done;
    logic        wr_drop;
    logic [15:0] written;

    // 4 x 8 instance
    logic        clear2;
    logic [7:0]  bus_in2;
    logic        wr_en2;
    logic [1:0]  wr_sel2;
    logic [1:0]  rd_sel2;
    logic        ba_out2;
    logic [7:0]  rd_data2;
    logic        op_req2;
    logic        op_swap2;
    logic [1:0]  op_a2;
    logic [1:0]  op_b2;
    logic        op_busy2;
    logic        op_done2;
    logic        wr_drop2;
    logic [3:0]  written2;

    gp_register_bank #(
        .WIDTH(32), .NUM_REGS(16), .RESET_VALUE(32'h0), .R0_GATED(1'b1)
    ) dut (
        .clock(clk), .clear(clear), .bus_in(bus_in), .wr_en(wr_en),
        .wr_sel(wr_sel), .rd_sel(rd_sel), .ba_out(ba_out), .rd_data(rd_data),
        .op_req(op_req), .op_swap(op_swap), .op_a(op_a), .op_b(op_b),
        .op_busy(op_busy), .op_done(op_done), .wr_drop(wr_drop),
        .written(written)
    );

    gp_register_bank #(
        .WIDTH(8), .NUM_REGS(4), .RESET_VALUE(8'h0), .R0_GATED(1'b1)
    ) dut2 (
        .clock(clk), .clear(clear2), .bus_in(bus_in2), .wr_en(wr_en2),
        .wr_sel(wr_sel2), .rd_sel(rd_sel2), .ba_out(ba_out2),
        .rd_data(rd_data2), .op_req(op_req2), .op_swap(op_swap2),
        .op_a(op_a2), .op_b(op_b2), .op_busy(op_busy2), .op_done(op_done2),
        .wr_drop(wr_drop2), .written(written2)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] model [16];
    logic [15:0] model_wr;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
    } chk_t;

    chk_t chk_q[$];
    int   done_q[$];
    logic chk_strobe = 1'b0;
    int   busy_cnt   = 0;
    int   done2_cnt  = 0;

    // Monitor
    always @(negedge clk) begin
        chk_t        c;
        logic [31:0] act;
        int          e;
        if (!clear) begin
            busy_cnt = 0;
        end else begin
            if (op_busy) busy_cnt++;
            if (op_done) begin
                checks++;
                if (done_q.size() == 0) begin
                    errors++;
                    $display("FAIL op_done_unexpected: got 1 required 0");
                end else begin
                    e = done_q.pop_front();
                    if (busy_cnt != e) begin
                        errors++;
                        $display("FAIL op_latency: busy cycles got %0d required %0d",
                                 busy_cnt, e);
                    end
                end
                busy_cnt = 0;
            end
        end
        if (clear2 && op_done2) done2_cnt++;
        if (chk_strobe) begin
            while (chk_q.size() > 0) begin
                c = chk_q.pop_front();
                case (c.kind)
                    0:       act = rd_data;
                    1:       act = {31'h0, wr_drop};
                    2:       act = {16'h0, written};
                    3:       act = {31'h0, op_busy};
                    4:       act = {31'h0, op_done};
                    5:       act = {24'h0, rd_data2};
                    6:       act = {28'h0, written2};
                    7:       act = {31'h0, op_busy2};
                    default: act = done2_cnt;
                endcase
                checks++;
                if (act !== c.exp) begin
                    errors++;
                    $display("FAIL %s: got %h required %h", c.name, act, c.exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string n, input int k, input logic [31:0] e);
        chk_t c;
        c.name = n;
        c.kind = k;
        c.exp  = e;
        chk_q.push_back(c);
    endtask

    task automatic strobe();
        chk_strobe = 1'b1;
        tick();
        chk_strobe = 1'b0;
    endtask

    task automatic check_read(input int sel, input bit ba, input string n);
        rd_sel = sel[3:0];
        ba_out = ba;
        push(n, 0, (ba && sel == 0) ? 32'h0 : model[sel]);
        strobe();
        ba_out = 1'b0;
    endtask

    task automatic check_written(input string n);
        push(n, 2, {16'h0, model_wr});
        strobe();
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
        model_wr = 16'h0;
    endtask

    task automatic do_write(input int sel, input logic [31:0] v);
        wr_en  = 1'b1;
        wr_sel = sel[3:0];
        bus_in = v;
        tick();
        wr_en = 1'b0;
        model[sel]    = v;
        model_wr[sel] = 1'b1;
    endtask

    task automatic do_op(input int a, input int b, input bit swap,
                         input bit with_wr, input int wsel,
                         input logic [31:0] wv, input bit expect_done);
        logic [31:0] t;
        op_req  = 1'b1;
        op_a    = a[3:0];
        op_b    = b[3:0];
        op_swap = swap;
        if (with_wr) begin
            wr_en  = 1'b1;
            wr_sel = wsel[3:0];
            bus_in = wv;
            model[wsel]    = wv;
            model_wr[wsel] = 1'b1;
        end
        if (expect_done) begin
            done_q.push_back(swap ? 3 : 2);
            if (swap) begin
                t        = model[a];
                model[a] = model[b];
                model[b] = t;
                model_wr[a] = 1'b1;
            end else begin
                model[b] = model[a];
            end
            model_wr[b] = 1'b1;
        end
        tick();
        op_req = 1'b0;
        wr_en  = 1'b0;
    endtask

    task automatic wait_done(input string n);
        int k;
        k = 0;
        while (!op_done && k < 10) begin
            tick();
            k++;
        end
        if (!op_done) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout, op_done got 0 required 1", n);
        end
    endtask

    initial begin
        int a;
        int b;
        clear = 1'b0; bus_in = '0; wr_en = 1'b0; wr_sel = '0; rd_sel = '0;
        ba_out = 1'b0; op_req = 1'b0; op_swap = 1'b0; op_a = '0; op_b = '0;
        clear2 = 1'b0; bus_in2 = '0; wr_en2 = 1'b0; wr_sel2 = '0;
        rd_sel2 = '0; ba_out2 = 1'b0; op_req2 = 1'b0; op_swap2 = 1'b0;
        op_a2 = '0; op_b2 = '0;
        model_reset();
        tick();
        clear  = 1'b1;
        clear2 = 1'b1;

        // Reset state
        for (int i = 0; i < 16; i++) check_read(i, 1'b0, "reset_rd");
        check_written("reset_written");
        push("reset_busy", 3, 32'h0);
        push("reset_done", 4, 32'h0);
        push("reset_wr_drop", 1, 32'h0);
        strobe();

        // Write and read-back with R0 gating
        do_write(0, 32'hDEADBEEF);
        do_write(15, 32'h12345678);
        check_read(0, 1'b0, "r0_plain");
        check_read(0, 1'b1, "r0_gated");
        check_read(15, 1'b0, "r15");
        push("written_8001", 2, 32'h0000_8001);
        strobe();

        // Move
        do_write(3, 32'hA5A5A5A5);
        do_op(3, 7, 1'b0, 1'b0, 0, 32'h0, 1'b1);
        wait_done("move");
        tick();
        push("move_done_one_cycle", 4, 32'h0);
        strobe();
        check_read(7, 1'b0, "move_r7");
        check_read(3, 1'b0, "move_r3");

        // Swap with a write dropped during T2
        do_write(1, 32'h1);
        do_write(2, 32'h2);
        do_op(1, 2, 1'b1, 1'b0, 0, 32'h0, 1'b1);
        tick();
        wr_en  = 1'b1;
        wr_sel = 4'd4;
        bus_in = 32'h9;
        push("swap_wr_drop", 1, 32'h1);
        push("swap_busy_t2", 3, 32'h1);
        strobe();
        wr_en = 1'b0;
        wait_done("swap");
        tick();
        check_read(1, 1'b0, "swap_r1");
        check_read(2, 1'b0, "swap_r2");
        check_read(4, 1'b0, "dropped_r4");
        check_written("swap_written");

        // Same-cycle write and request
        do_op(5, 6, 1'b0, 1'b1, 5, 32'h55, 1'b1);
        wait_done("same_cycle");
        tick();
        check_read(6, 1'b0, "same_cycle_r6");
        check_read(5, 1'b0, "same_cycle_r5");

        // Back-to-back: second request issued while in DONE
        do_op(6, 8, 1'b0, 1'b0, 0, 32'h0, 1'b1);
        wait_done("b2b_first");
        do_op(8, 9, 1'b1, 1'b0, 0, 32'h0, 1'b1);
        wait_done("b2b_second");
        tick();
        check_read(8, 1'b0, "b2b_r8");
        check_read(9, 1'b0, "b2b_r9");

        // Same operand swap
        do_op(15, 15, 1'b1, 1'b0, 0, 32'h0, 1'b1);
        wait_done("same_operand");
        tick();
        check_read(15, 1'b0, "same_operand_r15");

        // Reset mid-operation (in T2)
        do_op(10, 11, 1'b1, 1'b0, 0, 32'h0, 1'b0);
        tick();
        clear = 1'b0;
        tick();
        clear = 1'b1;
        model_reset();
        push("midreset_busy", 3, 32'h0);
        push("midreset_done", 4, 32'h0);
        strobe();
        for (int i = 0; i < 16; i++) check_read(i, 1'b0, "midreset_rd");
        check_written("midreset_written");
        repeat (4) tick();

        // Randomized traffic against the model
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 2))
                0: do_write($urandom_range(0, 15), $urandom);
                1: begin
                    a = $urandom_range(0, 15);
                    b = ($urandom_range(0, 3) == 0) ? a : $urandom_range(0, 15);
                    do_op(a, b, 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), $urandom_range(0, 15),
                          $urandom, 1'b1);
                    wait_done("rand_op");
                    tick();
                end
                default: check_read($urandom_range(0, 15),
                                    1'($urandom_range(0, 1)), "rand_rd");
            endcase
        end
        for (int i = 0; i < 16; i++) check_read(i, 1'b0, "final_rd");
        check_written("final_written");

        // Small build: mid-operation reset then a move
        wr_en2 = 1'b1; wr_sel2 = 2'd1; bus_in2 = 8'hA5; tick();
        wr_sel2 = 2'd2; bus_in2 = 8'h3C; tick();
        wr_en2 = 1'b0;
        op_req2 = 1'b1; op_swap2 = 1'b1; op_a2 = 2'd1; op_b2 = 2'd2; tick();
        op_req2 = 1'b0;
        tick();
        clear2 = 1'b0;
        tick();
        clear2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd_sel2 = i[1:0];
            push("d2_midreset_rd", 5, 32'h0);
            strobe();
        end
        push("d2_midreset_written", 6, 32'h0);
        push("d2_midreset_busy", 7, 32'h0);
        push("d2_no_done", 8, 32'h0);
        strobe();
        wr_en2 = 1'b1; wr_sel2 = 2'd1; bus_in2 = 8'h7E; tick();
        wr_en2 = 1'b0;
        op_req2 = 1'b1; op_swap2 = 1'b0; op_a2 = 2'd1; op_b2 = 2'd3; tick();
        op_req2 = 1'b0;
        repeat (4) tick();
        rd_sel2 = 2'd3;
        push("d2_move_r3", 5, 32'h7E);
        push("d2_done_count", 8, 32'h1);
        push("d2_written", 6, 32'hA);
        strobe();

        checks++;
        if (done_q.size() != 0) begin
            errors++;
            $display("FAIL pending_done: got %0d outstanding required 0",
                     done_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
